// File: rtl/gpu_cmd_pkg.sv
// ==== gpu_cmd_pkg -- shared opcodes, state type and width helper for cmd_sequencer ====
// Revision: 1.0
`default_nettype none

package gpu_cmd_pkg;

  localparam logic [3:0] CTRL_ADDR = 4'd0;

  localparam logic [3:0] OP_START_TILE  = 4'd0;
  localparam logic [3:0] OP_WAIT_TILE   = 4'd1;
  localparam logic [3:0] OP_START_WRITE = 4'd2;
  localparam logic [3:0] OP_WAIT_WRITE  = 4'd3;
  localparam logic [3:0] OP_WAIT_RAM    = 4'd4;
  localparam logic [3:0] OP_RESET_SEQ   = 4'd5;
  localparam logic [3:0] OP_SELECT      = 4'd6;
  localparam logic [3:0] OP_WAIT_ALL    = 4'd7;
  localparam logic [3:0] OP_FENCE       = 4'd8;
  localparam logic [3:0] OP_CLEAR       = 4'd9;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_t;

  // Channel index width; never below one bit so a single-channel build still has a port.
  function automatic int cw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_watchdog.sv
// ==== cmd_watchdog -- stall counter that forces a blocked command through ====
// Revision: 1.0
`default_nettype none

module cmd_watchdog #(
  parameter int TIMEOUT = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic clear,
  output logic force_accept
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign force_accept = 1'b0;
    end else begin : g_enabled
      localparam int              CNT_W   = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);

      logic [CNT_W-1:0] r_count;

      // Saturates at the limit; the forced accept clears it on the following edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (stall && (r_count != C_LIMIT)) begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      assign force_accept = (r_count == C_LIMIT);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cmd_sequencer.sv
// ==== cmd_sequencer -- decodes the GPU command stream into channel start pulses ====
// Revision: 1.0
`default_nettype none

module cmd_sequencer
  import gpu_cmd_pkg::*;
#(
  parameter  int NUM_CH  = 2,
  parameter  int TIMEOUT = 1048576,
  localparam int CW      = cw_of(NUM_CH)
) (
  input  logic              gpu_clk,
  input  logic              gpu_resetn,
  input  logic              cmd_valid,
  input  logic [3:0]        cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic              cmd_ready,
  output logic [NUM_CH-1:0] tile_start,
  input  logic [NUM_CH-1:0] tile_done,
  output logic [NUM_CH-1:0] write_start,
  input  logic [NUM_CH-1:0] writing,
  input  logic              writer_busy,
  output logic              param_we,
  output logic [3:0]        param_addr,
  output logic [31:0]       param_data,
  output logic [CW-1:0]     param_chan,
  output logic [CW-1:0]     cur_chan,
  output logic [31:0]       seq_no,
  output logic              fence_irq,
  output logic              err,
  output logic              timeout
);

  localparam logic [NUM_CH-1:0] C_ONE = NUM_CH'(1);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic [CW-1:0]    r_cur_chan;
  logic             w_is_ctrl;
  logic [3:0]       w_opcode;
  logic [2:0]       w_sel;
  logic             w_sel_ok;
  logic             w_cond;
  logic             w_force;
  logic             w_accept;
  logic             w_drop;
  logic             w_stall;
  logic             w_clear;

  assign w_is_ctrl = (cmd_addr == CTRL_ADDR);
  assign w_opcode  = cmd_data[3:0];
  assign w_sel     = cmd_data[6:4];
  assign w_sel_ok  = ({29'd0, w_sel} < 32'(NUM_CH));
  assign cur_chan  = r_cur_chan;

  always_ff @(posedge gpu_clk or negedge gpu_resetn) begin
    if (!gpu_resetn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ready is gated by reset so the pop strobe is low for the whole reset window.
  always_comb begin
    w_cond       = 1'b1;
    w_state_next = ST_RUN;
    if (w_is_ctrl) begin
      case (w_opcode)
        OP_START_TILE:  w_cond = tile_done[r_cur_chan] && !writing[r_cur_chan];
        OP_WAIT_TILE:   w_cond = tile_done[r_cur_chan];
        OP_START_WRITE: w_cond = tile_done[r_cur_chan] && (writing == '0) && !writer_busy;
        OP_WAIT_WRITE:  w_cond = !writing[r_cur_chan];
        OP_WAIT_RAM:    w_cond = !writer_busy;
        OP_WAIT_ALL:    w_cond = (&tile_done) && (writing == '0) && !writer_busy;
        default:        w_cond = 1'b1;
      endcase
    end
    cmd_ready = gpu_resetn && cmd_valid && (r_state == ST_RUN) && (w_cond || w_force);
    w_accept  = cmd_ready;
    w_drop    = w_accept && w_force;
    w_stall   = (r_state == ST_RUN) && cmd_valid && !w_cond;
    w_clear   = w_accept || !cmd_valid;
    if ((r_state == ST_RUN) && w_accept && !w_drop && w_is_ctrl &&
        ((w_opcode == OP_START_TILE) || (w_opcode == OP_START_WRITE))) begin
      w_state_next = ST_HOLD;
    end
  end

  cmd_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk          (gpu_clk),
    .rst_n        (gpu_resetn),
    .stall        (w_stall),
    .clear        (w_clear),
    .force_accept (w_force)
  );

  always_ff @(posedge gpu_clk or negedge gpu_resetn) begin
    if (!gpu_resetn) begin
      tile_start  <= '0;
      write_start <= '0;
      param_we    <= 1'b0;
      param_addr  <= '0;
      param_data  <= '0;
      param_chan  <= '0;
      fence_irq   <= 1'b0;
      r_cur_chan  <= '0;
      seq_no      <= '0;
      err         <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      tile_start  <= '0;
      write_start <= '0;
      param_we    <= 1'b0;
      fence_irq   <= 1'b0;
      if (w_accept) begin
        seq_no <= seq_no + 32'd1;
        if (w_drop) begin
          timeout <= 1'b1;
        end else if (!w_is_ctrl) begin
          param_we   <= 1'b1;
          param_addr <= cmd_addr;
          param_data <= cmd_data;
          param_chan <= r_cur_chan;
        end else begin
          case (w_opcode)
            OP_START_TILE:  tile_start  <= C_ONE << r_cur_chan;
            OP_START_WRITE: write_start <= C_ONE << r_cur_chan;
            OP_WAIT_TILE, OP_WAIT_WRITE, OP_WAIT_RAM, OP_WAIT_ALL: ;
            OP_RESET_SEQ:   seq_no <= '0;
            OP_SELECT: begin
              if (w_sel_ok) begin
                r_cur_chan <= w_sel[CW-1:0];
              end else begin
                err <= 1'b1;
              end
            end
            OP_FENCE:       fence_irq <= 1'b1;
            OP_CLEAR: begin
              err     <= 1'b0;
              timeout <= 1'b0;
            end
            default:        err <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
// ==== tb_cmd_sequencer -- directed scoreboard bench for cmd_sequencer ====
// Revision: 1.0
`default_nettype none

module tb_cmd_sequencer;
  import gpu_cmd_pkg::*;

  localparam int NUM_CH  = 2;
  localparam int TIMEOUT = 16;
  localparam int CW      = 1;

  logic              gpu_clk = 1'b0;
  logic              gpu_resetn;
  logic              cmd_valid;
  logic [3:0]        cmd_addr;
  logic [31:0]       cmd_data;
  logic              cmd_ready;
  logic [NUM_CH-1:0] tile_start;
  logic [NUM_CH-1:0] tile_done;
  logic [NUM_CH-1:0] write_start;
  logic [NUM_CH-1:0] writing;
  logic              writer_busy;
  logic              param_we;
  logic [3:0]        param_addr;
  logic [31:0]       param_data;
  logic [CW-1:0]     param_chan;
  logic [CW-1:0]     cur_chan;
  logic [31:0]       seq_no;
  logic              fence_irq;
  logic              err;
  logic              timeout;

  typedef struct packed {
    logic [1:0]  ts;
    logic [1:0]  ws;
    logic        pwe;
    logic [3:0]  pa;
    logic [31:0] pd;
    logic        pc;
    logic        fi;
  } pulse_t;

  pulse_t        sb[$];
  int            checks   = 0;
  int            failures = 0;
  logic [31:0]   exp_seq  = '0;
  logic [CW-1:0] exp_chan = '0;

  always #5 gpu_clk = ~gpu_clk;

  cmd_sequencer #(
    .NUM_CH  (NUM_CH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .gpu_clk     (gpu_clk),
    .gpu_resetn  (gpu_resetn),
    .cmd_valid   (cmd_valid),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .tile_start  (tile_start),
    .tile_done   (tile_done),
    .write_start (write_start),
    .writing     (writing),
    .writer_busy (writer_busy),
    .param_we    (param_we),
    .param_addr  (param_addr),
    .param_data  (param_data),
    .param_chan  (param_chan),
    .cur_chan    (cur_chan),
    .seq_no      (seq_no),
    .fence_irq   (fence_irq),
    .err         (err),
    .timeout     (timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic pulse_t mk(input logic [1:0] ts, input logic [1:0] ws, input logic pwe,
                                input logic [3:0] pa, input logic [31:0] pd, input logic pc,
                                input logic fi);
    pulse_t p;
    p.ts = ts; p.ws = ws; p.pwe = pwe; p.pa = pa; p.pd = pd; p.pc = pc; p.fi = fi;
    return p;
  endfunction

  // Parameter address/data legitimately hold their last value, so only compare them while strobed.
  function automatic pulse_t observe();
    pulse_t p;
    p.ts  = tile_start;
    p.ws  = write_start;
    p.pwe = param_we;
    p.pa  = param_we ? param_addr : 4'd0;
    p.pd  = param_we ? param_data : 32'd0;
    p.pc  = param_we ? param_chan : 1'b0;
    p.fi  = fence_irq;
    return p;
  endfunction

  task automatic check_pulses(input string tag);
    pulse_t e;
    pulse_t o;
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    o = observe();
    chk({tag, " pulses"}, 64'(o), 64'(e));
  endtask

  task automatic present(input logic [3:0] a, input logic [31:0] d);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(input string tag, input int budget, output int stalls);
    stalls = 0;
    #1;
    while (!cmd_ready && stalls < budget) begin
      @(posedge gpu_clk); #1;
      stalls++;
    end
    chk({tag, " ready"}, 64'(cmd_ready), 64'd1);
    if (cmd_ready) begin
      @(posedge gpu_clk); #1;
      exp_seq = exp_seq + 32'd1;
    end
    cmd_valid = 1'b0;
    check_pulses(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    gpu_resetn  = 1'b0;
    tile_done   = 2'b11;
    writing     = 2'b00;
    writer_busy = 1'b0;
    present(CTRL_ADDR, 32'(OP_START_TILE));
    repeat (2) @(posedge gpu_clk);
    #1;
    chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst pulses", 64'({tile_start, write_start, param_we, param_addr, param_data,
                           param_chan, fence_irq}), 64'd0);
    chk("rst seq_no", 64'(seq_no), 64'd0);
    chk("rst flags", 64'({cur_chan, err, timeout}), 64'd0);
    cmd_valid = 1'b0;
    @(negedge gpu_clk) gpu_resetn = 1'b1;
    @(posedge gpu_clk); #1;

    // START_TILE on channel 0, then HOLD blocks the next command for exactly one cycle
    present(CTRL_ADDR, 32'(OP_START_TILE));
    sb.push_back(mk(2'b01, 2'b00, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0));
    wait_accept("start_tile", 8, n);
    present(CTRL_ADDR, 32'(OP_WAIT_TILE));
    #1;
    chk("hold cmd_ready", 64'(cmd_ready), 64'd0);
    chk("seq after start_tile", 64'(seq_no), 64'd1);
    wait_accept("wait_tile", 4, n);
    chk("hold length", 64'(n), 64'd1);

    // SELECT 1, START_WRITE stalls on writing, fires on channel 1 once it clears
    present(CTRL_ADDR, 32'h16);
    wait_accept("select1", 4, n);
    exp_chan = 1'b1;
    chk("cur_chan select1", 64'(cur_chan), 64'(exp_chan));
    writing = 2'b01;
    present(CTRL_ADDR, 32'(OP_START_WRITE));
    repeat (4) begin @(posedge gpu_clk); #1; end
    chk("start_write stall", 64'(cmd_ready), 64'd0);
    writing = 2'b00;
    sb.push_back(mk(2'b00, 2'b10, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0));
    wait_accept("start_write", 4, n);
    chk("seq after start_write", 64'(seq_no), 64'(exp_seq));

    // Out-of-range SELECT and reserved opcode both raise err; CLEAR drops it
    present(CTRL_ADDR, 32'h06);
    wait_accept("select0", 4, n);
    exp_chan = 1'b0;
    present(CTRL_ADDR, 32'h56);
    wait_accept("select5", 4, n);
    chk("select5 err", 64'(err), 64'd1);
    chk("select5 cur_chan", 64'(cur_chan), 64'(exp_chan));
    present(CTRL_ADDR, 32'(OP_CLEAR));
    wait_accept("clear1", 4, n);
    chk("clear err", 64'(err), 64'd0);
    present(CTRL_ADDR, 32'h0C);
    wait_accept("reserved", 4, n);
    chk("reserved err", 64'(err), 64'd1);
    present(CTRL_ADDR, 32'(OP_CLEAR));
    wait_accept("clear2", 4, n);

    present(CTRL_ADDR, 32'(OP_FENCE));
    sb.push_back(mk(2'b00, 2'b00, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1));
    wait_accept("fence", 4, n);

    tile_done = 2'b10;
    present(CTRL_ADDR, 32'(OP_WAIT_ALL));
    repeat (3) begin @(posedge gpu_clk); #1; end
    chk("wait_all stall", 64'(cmd_ready), 64'd0);
    tile_done = 2'b11;
    wait_accept("wait_all", 4, n);

    // Watchdog drops WAIT_RAM after TIMEOUT stall cycles
    writer_busy = 1'b1;
    present(CTRL_ADDR, 32'(OP_WAIT_RAM));
    wait_accept("wait_ram drop", 40, n);
    chk("wait_ram stall cycles", 64'(n), 64'(TIMEOUT));
    chk("wait_ram timeout flag", 64'({err, timeout}), 64'b01);
    chk("seq after drop", 64'(seq_no), 64'(exp_seq));
    writer_busy = 1'b0;

    // A dropped START_TILE must neither pulse nor enter HOLD
    tile_done = 2'b00;
    present(CTRL_ADDR, 32'(OP_START_TILE));
    wait_accept("start_tile drop", 40, n);
    chk("start_tile drop cycles", 64'(n), 64'(TIMEOUT));
    tile_done = 2'b11;
    present(CTRL_ADDR, 32'(OP_CLEAR));
    wait_accept("clear3", 4, n);
    chk("clear after drop", 64'(n), 64'd0);
    chk("clear timeout", 64'(timeout), 64'd0);

    present(CTRL_ADDR, 32'(OP_RESET_SEQ));
    wait_accept("reset_seq", 4, n);
    exp_seq = '0;
    chk("reset_seq value", 64'(seq_no), 64'd0);

    // seq_no wrap on a parameter write, then a back-to-back parameter write
    present(CTRL_ADDR, 32'h16);
    wait_accept("select1b", 4, n);
    exp_chan = 1'b1;
    force dut.seq_no = 32'hFFFF_FFFF;
    #1;
    release dut.seq_no;
    exp_seq = 32'hFFFF_FFFF;
    present(4'd3, 32'h0000_1234);
    sb.push_back(mk(2'b00, 2'b00, 1'b1, 4'd3, 32'h0000_1234, exp_chan, 1'b0));
    wait_accept("param wrap", 4, n);
    chk("seq wrap", 64'(seq_no), 64'(exp_seq));
    present(4'd15, 32'hDEAD_BEEF);
    sb.push_back(mk(2'b00, 2'b00, 1'b1, 4'd15, 32'hDEAD_BEEF, exp_chan, 1'b0));
    wait_accept("param b2b", 4, n);
    chk("param b2b latency", 64'(n), 64'd0);

    // Reset asserted while in HOLD clears everything in the same cycle
    present(CTRL_ADDR, 32'(OP_START_TILE));
    sb.push_back(mk(2'b10, 2'b00, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0));
    wait_accept("start_tile ch1", 4, n);
    present(CTRL_ADDR, 32'(OP_WAIT_TILE));
    gpu_resetn = 1'b0;
    #1;
    chk("hold rst pulses", 64'({tile_start, write_start, param_we, param_addr, param_data,
                                param_chan, fence_irq}), 64'd0);
    chk("hold rst state", 64'({cmd_ready, cur_chan, err, timeout, seq_no}), 64'd0);
    exp_seq  = '0;
    exp_chan = '0;
    @(negedge gpu_clk) gpu_resetn = 1'b1;
    #1;
    chk("post rst ready", 64'(cmd_ready), 64'd1);
    tile_done = 2'b10;
    #1;
    chk("post rst blocked", 64'(cmd_ready), 64'd0);
    tile_done = 2'b11;
    wait_accept("post rst wait_tile", 4, n);
    chk("post rst seq", 64'(seq_no), 64'(exp_seq));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
